// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store unit sitting between the EX/MEM pipeline register and
// a word-addressed data memory with combinational read and clocked write.
// RV32I LB/LH/LW/LBU/LHU loads complete in the request cycle with sign or
// zero extension. SW is a single-cycle word write. SB/SH are performed as a
// two-cycle read-modify-write: the first cycle reads the word and stalls the
// pipeline, the second cycle writes the merged word back. Misaligned,
// out-of-range and illegal-funct3 requests raise o_misaligned for the request
// cycle and produce no memory side effects.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_req_read     load request this cycle
//   i_req_write    store request this cycle (wins over i_req_read)
//   i_funct3       RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   i_addr         byte address from the ALU
//   i_store_data   rs2 value; byte/half taken from the low bits
//   o_load_data    extended load result, valid in the request cycle
//   o_stall        hold PC, IF/ID, ID/EX and EX/MEM this cycle
//   o_misaligned   access fault pulse
//   o_mem_addr     word-aligned byte address to data memory
//   o_mem_read     data memory read enable
//   o_mem_write    data memory write enable
//   o_mem_wdata    word to write
//   i_mem_rdata    data memory combinational read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_read,
    input  logic              i_req_write,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_store_data,
    output logic [31:0]       o_load_data,
    output logic              o_stall,
    output logic              o_misaligned,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [0:0]        r_state;
    logic [31:0]       r_merge;
    logic [ADDR_W-1:0] r_addr;

    logic [0:0]        w_next_state;
    logic              w_capture;
    logic              w_req;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_oor;
    logic              w_fault;
    logic              w_sub_store;
    logic [ADDR_W-1:0] w_word_addr;
    logic [31:0]       w_merge;

    // Select the addressed byte/half lane of a word and extend it per funct3.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [31:0] word,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            3'b010:  res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half lane of the old word with store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] sd,
                                               input logic [1:0]  lane,
                                               input logic        half);
        logic [31:0] res;
        res = old_word;
        if (half) begin
            if (lane[1]) begin
                res[31:16] = sd[15:0];
            end else begin
                res[15:0] = sd[15:0];
            end
        end else begin
            case (lane)
                2'd0:    res[7:0]   = sd[7:0];
                2'd1:    res[15:8]  = sd[7:0];
                2'd2:    res[23:16] = sd[7:0];
                default: res[31:24] = sd[7:0];
            endcase
        end
        return res;
    endfunction

    assign w_req       = i_req_read | i_req_write;
    assign w_oor       = |i_addr[31:ADDR_W];
    assign w_fault     = w_req & (w_illegal | w_misalign | w_oor);
    assign w_word_addr = {i_addr[ADDR_W-1:2], 2'b00};
    // funct3[1:0]==10 is the word width; every other legal code is byte/half.
    assign w_sub_store = (i_funct3[1:0] != 2'b10);
    assign w_merge     = merge_lane(i_mem_rdata, i_store_data, i_addr[1:0], i_funct3[0]);

    // Decode funct3 into illegal-code and alignment faults.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = i_addr[0];
            3'b010:         w_misalign = (i_addr[1:0] != 2'b00);
            default:        w_illegal  = 1'b1;
        endcase
    end

    // Next-state and memory-interface control for the IDLE/WRITE machine.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        o_load_data  = 32'd0;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_mem_addr   = {ADDR_W{1'b0}};
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_wdata  = 32'd0;
        if (i_rst) begin
            // Reset overrides everything, including an in-flight WRITE.
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fault) begin
                        o_misaligned = 1'b1;
                    end else if (i_req_write) begin
                        o_mem_addr = w_word_addr;
                        if (w_sub_store) begin
                            o_mem_read   = 1'b1;
                            o_stall      = 1'b1;
                            w_capture    = 1'b1;
                            w_next_state = S_WRITE;
                        end else begin
                            o_mem_write = 1'b1;
                            o_mem_wdata = i_store_data;
                        end
                    end else if (i_req_read) begin
                        o_mem_addr  = w_word_addr;
                        o_mem_read  = 1'b1;
                        o_load_data = load_extend(i_funct3, i_mem_rdata, i_addr[1:0]);
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_WRITE: begin
                    // Driven purely from latched state; live inputs are ignored.
                    o_mem_addr   = r_addr;
                    o_mem_write  = 1'b1;
                    o_mem_wdata  = r_merge;
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // State, merge word and latched address registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_merge <= 32'd0;
            r_addr  <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_merge <= w_merge;
                r_addr  <= w_word_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Scoreboard bench for mem_access_unit with a 16-word data memory. The
// stimulus process computes each expected response from a word-array model
// using byte arithmetic and pushes it into a queue; an independent monitor
// on the falling clock edge pops and compares whenever the DUT drives a
// memory enable or a fault, and checks quiet cycles otherwise.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] ld;
        bit          chk_ld;
        logic        mis;
        logic        stl;
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        bit          has_c;
        logic [31:0] cval;
        bit          has_ca;
        logic [5:0]  caddr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic [5:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    exp_t        exp_q[$];
    int          checks;
    int          failures;
    bit          done;

    mem_access_unit #(.ADDR_W(6)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_read   (req_read),
        .i_req_write  (req_write),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_store_data (store_data),
        .o_load_data  (load_data),
        .o_stall      (stall),
        .o_misaligned (misaligned),
        .o_mem_addr   (mem_addr),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end

    function automatic exp_t blank_exp();
        exp_t e;
        e.ld = 32'd0; e.chk_ld = 1'b0; e.mis = 1'b0; e.stl = 1'b0;
        e.rd = 1'b0; e.wr = 1'b0; e.addr = 6'd0; e.wdata = 32'd0;
        e.has_c = 1'b0; e.cval = 32'd0; e.has_ca = 1'b0; e.caddr = 6'd0;
        return e;
    endfunction

    // Monitor: compare DUT activity with the scoreboard every falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain: %0d expected responses never seen (want 0)", exp_q.size());
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (mem[i] !== ref_mem[i]) begin
                    failures++;
                    $display("FAIL mem_word[%0d]: got %h want %h", i, mem[i], ref_mem[i]);
                end
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (mem_read || mem_write || misaligned) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_access: rd=%b wr=%b mis=%b addr=%h rst=%b (want no activity)",
                         mem_read, mem_write, misaligned, mem_addr, rst);
            end else begin
                e  = exp_q.pop_front();
                ok = (misaligned === e.mis) && (stall === e.stl) &&
                     (mem_read === e.rd) && (mem_write === e.wr);
                if (e.chk_ld && load_data !== e.ld) ok = 1'b0;
                if ((e.rd || e.wr) && mem_addr !== e.addr) ok = 1'b0;
                if (e.wr && mem_wdata !== e.wdata) ok = 1'b0;
                if (e.has_c && ((e.wr ? mem_wdata : load_data) !== e.cval)) ok = 1'b0;
                if (e.has_ca && mem_addr !== e.caddr) ok = 1'b0;
                if (!ok) begin
                    failures++;
                    $display("FAIL response: got mis=%b stall=%b rd=%b wr=%b addr=%h wdata=%h ld=%h want mis=%b stall=%b rd=%b wr=%b addr=%h wdata=%h ld=%h const=%h",
                             misaligned, stall, mem_read, mem_write, mem_addr, mem_wdata, load_data,
                             e.mis, e.stl, e.rd, e.wr, e.addr, e.wdata, e.ld, e.cval);
                end
            end
        end else begin
            checks++;
            if (stall !== 1'b0 || load_data !== 32'd0) begin
                failures++;
                $display("FAIL quiet_cycle: stall=%b load_data=%h rst=%b (want 0/00000000)",
                         stall, load_data, rst);
            end
        end
    end

    // Reference load: pick bytes from the model word and extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input int w);
        logic [31:0] word;
        logic [31:0] v;
        word = ref_mem[a[5:2]];
        v    = word >> (8 * a[1:0]);
        if (w == 1) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Issue one request starting at posedge+1; returns at posedge+1 after it completes.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit c_en, input logic [31:0] cval,
                         input bit ca_en, input logic [5:0] caddr);
        exp_t        e;
        exp_t        e2;
        int          w;
        bit          illegal;
        bit          fault;
        logic [31:0] mask;
        logic [31:0] nw;
        req_read = rd; req_write = wr; funct3 = f3; addr = a; store_data = d;
        illegal = 1'b0;
        case (f3)
            3'd0, 3'd4: w = 1;
            3'd1, 3'd5: w = 2;
            3'd2:       w = 4;
            default: begin w = 4; illegal = 1'b1; end
        endcase
        fault = illegal || (a > 32'd63) || (w == 2 && a[0]) || (w == 4 && a[1:0] != 2'b00);
        e = blank_exp();
        e2 = blank_exp();
        e.addr = {a[5:2], 2'b00};
        if (!(rd || wr)) begin
            w = 0;
        end else if (fault) begin
            e.mis = 1'b1; e.chk_ld = 1'b1;
            exp_q.push_back(e);
        end else if (wr && w == 4) begin
            e.wr = 1'b1; e.wdata = d;
            e.has_c = c_en; e.cval = cval; e.has_ca = ca_en; e.caddr = caddr;
            exp_q.push_back(e);
            ref_mem[a[5:2]] = d;
        end else if (wr) begin
            e.rd = 1'b1; e.stl = 1'b1;
            exp_q.push_back(e);
            mask = ((w == 1) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * a[1:0]);
            nw   = (ref_mem[a[5:2]] & ~mask) | ((d << (8 * a[1:0])) & mask);
            e2 = e; e2.rd = 1'b0; e2.stl = 1'b0; e2.wr = 1'b1; e2.wdata = nw;
            e2.has_c = c_en; e2.cval = cval; e2.has_ca = ca_en; e2.caddr = caddr;
        end else begin
            e.rd = 1'b1; e.chk_ld = 1'b1; e.ld = ref_load(f3, a, w);
            e.has_c = c_en; e.cval = cval;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (e2.wr) begin
            // WRITE cycle: inputs should be ignored, so drive junk.
            req_read = 1'($urandom); req_write = 1'($urandom); funct3 = 3'($urandom);
            addr = $urandom; store_data = $urandom;
            exp_q.push_back(e2);
            ref_mem[a[5:2]] = e2.wdata;
            @(posedge clk);
            #1;
        end
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_read = 1'b0; req_write = 1'b0; funct3 = 3'($urandom);
            addr = $urandom; store_data = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;
        done = 1'b0; checks = 0; failures = 0;
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; store_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload every word through the DUT.
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 1'b1, 3'b010, 32'(4 * i), (i == 0) ? 32'h8000_00F1 : $urandom,
                  1'b0, 32'd0, 1'b0, 6'd0);
        end

        issue(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF1, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b100, 32'd0, 32'd0, 1'b1, 32'h0000_00F1, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b001, 32'd2, 32'd0, 1'b1, 32'hFFFF_8000, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b101, 32'd2, 32'd0, 1'b1, 32'h0000_8000, 1'b0, 6'd0);

        issue(1'b0, 1'b1, 3'b010, 32'd4, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b1, 32'h1234_5678, 1'b0, 6'd0);
        issue(1'b0, 1'b1, 3'b000, 32'd5, 32'h0000_00AB, 1'b1, 32'h1234_AB78, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b1, 32'h1234_AB78, 1'b0, 6'd0);
        issue(1'b0, 1'b1, 3'b001, 32'd6, 32'h0000_CAFE, 1'b1, 32'hCAFE_AB78, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b1, 32'hCAFE_AB78, 1'b0, 6'd0);

        // Fault cases; both requests high checks that write wins.
        issue(1'b1, 1'b0, 3'b010, 32'd2, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        issue(1'b0, 1'b1, 3'b001, 32'd3, 32'h0000_BEEF, 1'b0, 32'd0, 1'b0, 6'd0);
        issue(1'b0, 1'b1, 3'b010, 32'd64, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b011, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        issue(1'b1, 1'b1, 3'b010, 32'd12, 32'h0BAD_F00D, 1'b0, 32'd0, 1'b0, 6'd0);
        issue(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b1, 32'hCAFE_AB78, 1'b0, 6'd0);

        // Reset during the WRITE cycle of SB addr=8: no write must happen.
        begin
            exp_t e;
            req_read = 1'b0; req_write = 1'b1; funct3 = 3'b000; addr = 32'd8;
            store_data = 32'h0000_0077;
            e = blank_exp();
            e.rd = 1'b1; e.stl = 1'b1; e.addr = 6'd8;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            rst = 1'b1; req_write = 1'b1; req_read = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0; req_write = 1'b0; req_read = 1'b0;
        end
        issue(1'b1, 1'b0, 3'b010, 32'd8, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        issue(1'b0, 1'b1, 3'b000, 32'h3F, 32'h0000_005A, 1'b0, 32'd0, 1'b1, 6'h3C);
        issue(1'b1, 1'b0, 3'b100, 32'h3F, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'($urandom_range(64, 70));
            else             a = $urandom | 32'h0000_0100;
            r = $urandom_range(0, 9);
            case (r)
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2, 3:    f3 = 3'b010;
                4:       f3 = 3'b100;
                5:       f3 = 3'b101;
                6:       f3 = 3'($urandom);
                default: f3 = 3'($urandom_range(0, 2));
            endcase
            // Bias word accesses toward aligned addresses.
            if (f3 == 3'b010 && $urandom_range(0, 1) == 0) a = a & ~32'd3;
            r = $urandom_range(0, 4);
            issue(r < 2, r >= 2 && r < 4, f3, a, $urandom, 1'b0, 32'd0, 1'b0, 6'd0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        done = 1'b1;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the pipeline's EX/MEM register and the word-addressed data memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory reads and writes.
- Sign- or zero-extends loads; performs sub-word stores as a 2-cycle read-modify-write, stalling the pipeline.
- Flags misaligned and out-of-range accesses and suppresses their memory side effects.

Parameters:
- ADDR_W, 6, byte-address width of the data memory; memory holds 2^(ADDR_W-2) words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_read  in  1  load request this cycle
- req_write  in  1  store request this cycle; if both requests are high, write wins and the read is ignored
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value; byte/half taken from its low bits
- load_data  out  32  extended load result, valid in the request cycle
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- misaligned  out  1  access fault pulse (misaligned, out of range, or illegal funct3)
- mem_addr  out  ADDR_W  word-aligned byte address to data memory (low 2 bits always 0)
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- mem_wdata  out  32  word to write
- mem_rdata  in  32  data memory combinational read data

Behaviour:
- Memory interface: combinational read; write commits on posedge clk when mem_write=1.
- Reset (rst=1 at posedge):
  - State goes to IDLE and the merge register is cleared to 0.
  - While rst is high, stall, mem_write, mem_read and misaligned are 0, and load_data=0.
  - Reset during WRITE aborts the read-modify-write; no memory write occurs.
- Fault check (combinational, IDLE only):
  - H/HU with addr[0]≠0 is a fault; W with addr[1:0]≠0 is a fault.
  - addr[31:ADDR_W]≠0 is a fault.
  - Illegal funct3 (011, 110, 111) is a fault.
  - A fault pulses misaligned=1 for the request cycle. mem_write=0, stall=0, and load_data=0.
- FSM states: IDLE, WRITE.
- IDLE, load (req_read, no fault):
  - mem_read=1, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Lane selection: byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend the selected lane; BU/HU zero-extend it; W passes the word through.
  - 0 cycles of latency; stall=0.
- IDLE, SW (no fault): mem_write=1, mem_wdata=store_data; single cycle, stall=0.
- IDLE, SB/SH (no fault):
  - mem_read=1 and stall=1.
  - The merge register captures mem_rdata with the target lane replaced by store_data[7:0] (SB) or store_data[15:0] (SH).
  - Go to WRITE.
- WRITE:
  - mem_write=1, mem_wdata=merge register, mem_addr from the latched address, stall=0, mem_read=0.
  - Inputs are ignored in this state; return to IDLE.
  - The next request is sampled in the following cycle.
- No request: all memory enables are 0, stall=0, load_data=0.
- Address latch: captured with the merge register, so WRITE never depends on live inputs.
- Store-then-load: a load in the cycle after WRITE sees the new word (memory commit precedes the combinational read).
- Highest word index, (2^(ADDR_W)-4): legal. addr=2^ADDR_W: out-of-range fault, with no wrap-around.

Test Plan:
- Preload word0=0x8000_00F1. LB addr=0 → load_data=0xFFFF_FFF1. LBU addr=0 → 0x0000_00F1. LH addr=2 → 0xFFFF_8000. LHU addr=2 → 0x0000_8000. All with stall=0.
- SW addr=4, data=0x1234_5678 → one-cycle mem_write, stall=0; LW addr=4 → 0x1234_5678.
- Word1=0x1234_5678, SB addr=5, data=0xAB → cycle 1 stall=1, mem_read=1; cycle 2 mem_write=1, mem_wdata=0x1234_AB78; LW addr=4 → 0x1234_AB78.
- SH addr=6, data=0xCAFE over 0x1234_AB78 → mem_wdata=0xCAFE_AB78 after a 1-cycle stall.
- Faults, each with misaligned=1, mem_write=0, stall=0, and memory unchanged:
  - LW addr=2
  - SH addr=3
  - SW addr=64 (ADDR_W=6)
  - funct3=011
- Reset asserted in the WRITE cycle of SB addr=8 → no write, word2 unchanged, state IDLE, stall=0. Then SB to addr=0x3F (last byte) → merged write lands at mem_addr=0x3C.
